chunk_ctx_scheduler: RTL

- Round-robin scheduler that shares one chunk processor between NUM_REQ context requesters.
- Accepts one SHA-256 context per grant and holds it stable at the chunk processor's context input for the whole job.
- Snoops the chunk-out handshake and predicts the chunk count from the context length. This lets it flag the final chunk and report job completion to the winning requester.

---
 rtl/chunk_ctx_scheduler.sv | 108 ++++++++++
 1 files changed

// File: rtl/chunk_ctx_scheduler.sv
// chunk_ctx_scheduler: round-robin SHA-256 context arbiter with chunk-count tracking for one chunk processor
package sha256_pkg;
  typedef struct packed {
    logic [511:0] buffer;
    logic [63:0]  length;
  } ShaContext;
endpackage

module chunk_ctx_scheduler #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_vld,
  output logic [NUM_REQ-1:0]    req_rdy,
  input  sha256_pkg::ShaContext req_ctx [NUM_REQ],
  input  logic                  cp_ctx_rdy,
  output logic                  cp_ctx_vld,
  output sha256_pkg::ShaContext cp_ctx,
  input  logic                  cp_chunk_vld,
  input  logic                  cp_chunk_rdy,
  output logic                  chunk_last,
  output logic                  busy,
  output logic [ID_W-1:0]       active_id,
  output logic [58:0]           chunks_left,
  output logic                  done_vld,
  output logic [ID_W-1:0]       done_id,
  output logic [58:0]           done_chunks,
  output logic                  err_spurious
);
  typedef enum logic [1:0] {IDLE, ISSUE, RUN, DONE} state_t;
  localparam logic [ID_W:0]   NR   = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST = ID_W'(NUM_REQ - 1);
  state_t          state;
  logic [ID_W-1:0] rr, win;
  logic [ID_W:0]   idx;
  logic            found, hs;
  logic [58:0]     total, total_w;
  always_comb begin
    win = '0;
    found = 1'b0;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr} + (ID_W+1)'(i);
      idx = idx >= NR ? idx - NR : idx;
      if (!found && req_vld[idx[ID_W-1:0]]) begin
        found = 1'b1;
        win = idx[ID_W-1:0];
      end
    end
  end
  // padding adds 0x80 plus the 8-byte length field, hence +72 before dividing by 64
  assign total_w = 59'(({1'b0, req_ctx[win].length} + 65'd72) >> 6);
  assign hs = cp_chunk_vld && cp_chunk_rdy;
  assign chunk_last = state == RUN && cp_chunk_vld && chunks_left == 59'd1;
  assign busy = state != IDLE;
  always_comb begin
    req_rdy = '0;
    req_rdy[win] = rst_n && state == IDLE && found;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr           <= '0;
      cp_ctx       <= '0;
      cp_ctx_vld   <= 1'b0;
      active_id    <= '0;
      chunks_left  <= '0;
      total        <= '0;
      done_vld     <= 1'b0;
      done_id      <= '0;
      done_chunks  <= '0;
      err_spurious <= 1'b0;
    end else begin
      done_vld <= 1'b0;
      if (hs && state != RUN) err_spurious <= 1'b1;
      case (state)
        IDLE: if (found) begin
          cp_ctx      <= req_ctx[win];
          active_id   <= win;
          chunks_left <= total_w;
          total       <= total_w;
          rr          <= win == LAST ? '0 : win + 1'b1;
          cp_ctx_vld  <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: if (cp_ctx_rdy) begin
          cp_ctx_vld <= 1'b0;
          state      <= RUN;
        end
        RUN: if (hs) begin
          chunks_left <= chunks_left - 1'b1;
          if (chunks_left == 59'd1) begin
            state       <= DONE;
            done_vld    <= 1'b1;
            done_id     <= active_id;
            done_chunks <= total;
          end
        end
        default: begin
          chunks_left <= '0;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule
